// File: rtl/clk_chk.sv
// Clock checker: sequences a downstream reset release, then counts mon_i rising edges per window and flags range.
// Latency: mon_i edge counted 3 clk_i cycles after it rises; window result and meas_vld_o registered at window close.
// Backpressure: none; meas_vld_o is a one-cycle strobe, consumers must sample it when it fires.
//
// Ports:
//   clk_i        single clock, all logic on its rising edge
//   rstl_i       asynchronous active-low reset (deassertion synchronized internally)
//   en_i         block enable, synchronous to clk_i; low returns to IDLE next cycle
//   mon_i        monitored clock/strobe, asynchronous to clk_i
//   rsth_o       synchronous active-high reset for downstream logic (high outside RUN)
//   rdy_o        high while in RUN
//   meas_vld_o   one-cycle pulse at each window close
//   freq_ok_o    last completed window count within [P_CNT_MIN, P_CNT_MAX]
//   meas_cnt_o   (only with CLK_CHK_CNT_OUT_EN defined) last completed window count
//
// Optional feature macro: CLK_CHK_CNT_OUT_EN adds the meas_cnt_o port and its register.

module clk_chk #(
    parameter int P_RST_RELEASE_CYCLES = 16,
    parameter int P_WIN_CYCLES         = 1000,
    parameter int P_CNT_MIN            = 90,
    parameter int P_CNT_MAX            = 110
) (
    input  logic        clk_i,
    input  logic        rstl_i,
    input  logic        en_i,
    input  logic        mon_i,
    output logic        rsth_o,
    output logic        rdy_o,
    output logic        meas_vld_o,
    output logic        freq_ok_o
`ifdef CLK_CHK_CNT_OUT_EN
    ,
    output logic [15:0] meas_cnt_o
`endif
);

    localparam logic [15:0] REL_LAST = 16'(P_RST_RELEASE_CYCLES - 1);
    localparam logic [15:0] WIN_LAST = 16'(P_WIN_CYCLES - 1);
    localparam logic [15:0] CNT_MIN  = 16'(P_CNT_MIN);
    localparam logic [15:0] CNT_MAX  = 16'(P_CNT_MAX);
    localparam logic [15:0] CNT_SAT  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  rst_sync;
    logic        rst_ok;

    logic [2:0]  mon_sync;
    logic        mon_edge;

    logic [15:0] rel_cnt;
    logic [15:0] rel_cnt_nxt;
    logic [15:0] win_cnt;
    logic [15:0] win_cnt_nxt;
    logic [15:0] edge_cnt;
    logic [15:0] edge_cnt_nxt;
    logic [15:0] edge_cnt_inc;
    logic        win_close;
    logic        cnt_in_range;

    // Reset assertion acts immediately through the async clear; release is
    // seen by the FSM only after two clk_i edges, so it cannot leave IDLE
    // on a metastable deassertion.
    always_ff @(posedge clk_i or negedge rstl_i) begin
        if (!rstl_i) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_ok = rst_sync[1];

    // Two synchronizer stages plus one history stage for edge detection.
    always_ff @(posedge clk_i or negedge rstl_i) begin
        if (!rstl_i) begin
            mon_sync <= 3'b000;
        end else begin
            mon_sync <= {mon_sync[1:0], mon_i};
        end
    end

    assign mon_edge = mon_sync[1] & ~mon_sync[2];

    // Count including this cycle's edge, saturating rather than wrapping so
    // a runaway input still reads as out of range.
    assign edge_cnt_inc = (mon_edge && (edge_cnt != CNT_SAT)) ? (edge_cnt + 16'd1) : edge_cnt;

    assign cnt_in_range = (edge_cnt_inc >= CNT_MIN) && (edge_cnt_inc <= CNT_MAX);

    // Next-state and counter logic. Counters default to zero so any state
    // other than the one that owns them keeps them cleared.
    always_comb begin
        state_nxt    = state;
        rel_cnt_nxt  = 16'd0;
        win_cnt_nxt  = 16'd0;
        edge_cnt_nxt = 16'd0;
        win_close    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (en_i && rst_ok) begin
                    state_nxt = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (!en_i) begin
                    state_nxt = ST_IDLE;
                end else if (rel_cnt == REL_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    rel_cnt_nxt = rel_cnt + 16'd1;
                end
            end

            ST_RUN: begin
                if (!en_i) begin
                    // Partial window is dropped: no close strobe.
                    state_nxt = ST_IDLE;
                end else if (win_cnt == WIN_LAST) begin
                    // Window and edge counters restart from zero.
                    win_close = 1'b1;
                end else begin
                    win_cnt_nxt  = win_cnt + 16'd1;
                    edge_cnt_nxt = edge_cnt_inc;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change in the same
    // cycle as the state itself, without decode glitches on rsth_o.
    always_ff @(posedge clk_i or negedge rstl_i) begin
        if (!rstl_i) begin
            state      <= ST_IDLE;
            rel_cnt    <= 16'd0;
            win_cnt    <= 16'd0;
            edge_cnt   <= 16'd0;
            rsth_o     <= 1'b1;
            rdy_o      <= 1'b0;
            meas_vld_o <= 1'b0;
            freq_ok_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            rel_cnt    <= rel_cnt_nxt;
            win_cnt    <= win_cnt_nxt;
            edge_cnt   <= edge_cnt_nxt;
            rsth_o     <= (state_nxt != ST_RUN);
            rdy_o      <= (state_nxt == ST_RUN);
            meas_vld_o <= win_close;
            if (state_nxt != ST_RUN) begin
                freq_ok_o <= 1'b0;
            end else if (win_close) begin
                freq_ok_o <= cnt_in_range;
            end
        end
    end

`ifdef CLK_CHK_CNT_OUT_EN
    // Holds the last completed window count, including across disable.
    always_ff @(posedge clk_i or negedge rstl_i) begin
        if (!rstl_i) begin
            meas_cnt_o <= 16'd0;
        end else if (win_close) begin
            meas_cnt_o <= edge_cnt_inc;
        end
    end
`endif

endmodule

// File: doc/clk_chk.md
CLK_CHK -- requirements
Module: clk_chk

Interface
REQ-001 Parameter P_RST_RELEASE_CYCLES, default 16: clk_i cycles that rsth_o is held in HOLD after enable; range 1..65535.
REQ-002 Parameter P_WIN_CYCLES, default 1000: measurement window length in clk_i cycles; range 2..65535.
REQ-003 Parameter P_CNT_MIN, default 90: minimum acceptable mon_i rising-edge count per window.
REQ-004 Parameter P_CNT_MAX, default 110: maximum acceptable mon_i rising-edge count per window; P_CNT_MIN <= P_CNT_MAX required.
REQ-005 clk_i  input  1  the single clock; all logic on its rising edge.
REQ-006 rstl_i  input  1  asynchronous, active-low reset.
REQ-007 en_i  input  1  block enable, synchronous to clk_i.
REQ-008 mon_i  input  1  monitored clock or strobe, asynchronous to clk_i.
REQ-009 rsth_o  output  1  synchronous active-high reset for downstream logic.
REQ-010 rdy_o  output  1  high while state is RUN.
REQ-011 meas_vld_o  output  1  one-cycle pulse at each window close.
REQ-012 freq_ok_o  output  1  result of the last completed window: count within [P_CNT_MIN, P_CNT_MAX].

Function
REQ-013 FSM states: IDLE, HOLD, RUN; encoding is free.
REQ-014 IDLE: rsth_o=1, rdy_o=0; en_i=1 -> HOLD next cycle, release counter cleared.
REQ-015 HOLD: rsth_o=1; release counter increments each cycle; at count P_RST_RELEASE_CYCLES-1 -> RUN, so rsth_o stays high exactly P_RST_RELEASE_CYCLES cycles in HOLD.
REQ-016 RUN: rsth_o=0, rdy_o=1; window and edge counters start at 0 on RUN entry.
REQ-017 en_i=0 in any state -> IDLE next cycle; rsth_o=1 and freq_ok_o=0 in that same next cycle; all counters cleared.
REQ-018 mon_i passes through a 2-flop synchronizer, then a third flop; a rising edge is sync=1 and third-flop=0, counted 3 cycles after mon_i rises.
REQ-019 Window counter runs 0..P_WIN_CYCLES-1 in RUN, then wraps to 0.
REQ-020 Edge counter is 16 bits and saturates at 65535; it never wraps.
REQ-021 On the last window cycle: an edge detected in that cycle is included; meas_vld_o=1 for one cycle; freq_ok_o is registered from the final count; edge counter restarts at 0.
REQ-022 freq_ok_o holds its value between window closes; the first valid value appears with the first meas_vld_o pulse.
REQ-023 Mid-window en_i drop or reset discards the partial count; no meas_vld_o pulse is produced for that window.

Reset
REQ-024 rstl_i=0 asynchronously forces: state IDLE, rsth_o=1, rdy_o=0, meas_vld_o=0, freq_ok_o=0, all counters and synchronizer flops 0.
REQ-025 rstl_i deassertion passes through an internal 2-flop synchronizer; the FSM leaves IDLE no earlier than the 2nd clk_i edge after rstl_i rises.

Configuration
REQ-026 Macro CLK_CHK_CNT_OUT_EN defined: extra output meas_cnt_o (16-bit) holds the last completed window count, updated with meas_vld_o, reset to 0.
REQ-027 CLK_CHK_CNT_OUT_EN undefined: meas_cnt_o port and its register are absent; all other behaviour is identical.

Verification
REQ-028 Defaults; rstl_i released; en_i=1; mon_i toggles every 5 clk_i cycles -> rsth_o high 16 cycles in HOLD; first meas_vld_o 1000 cycles after RUN entry; count 100; freq_ok_o=1.
REQ-029 mon_i held at 0 -> meas_vld_o pulses every 1000 cycles; freq_ok_o=0; meas_cnt_o=0 when the macro is defined.
REQ-030 mon_i toggles every 2 cycles (250 edges) -> freq_ok_o=0; then every 6 cycles (about 83 edges) -> freq_ok_o=0.
REQ-031 en_i dropped at window cycle 500 -> next cycle IDLE, rsth_o=1, freq_ok_o=0; no meas_vld_o; re-enable -> full HOLD then new window.
REQ-032 rstl_i pulsed low mid-HOLD and mid-RUN -> outputs immediately at reset values; restart gives the full 16-cycle HOLD.
REQ-033 Edge on the final window cycle (P_WIN_CYCLES=10) -> counted in the closing window; the next window starts at 0.
